div_ctrl: RTL and testbench
===========================

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter N, default 16, sets the operand and result width in bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  reset; synchronous, active-low.
REQ-004 req_valid  input  1  decode presents a divide request.
REQ-005 req_ready  output  1  block can accept a request; high only in IDLE.
REQ-006 req_op  input  2  operation: 0=DIV, 1=DIVU, 2=REM, 3=REMU.
REQ-007 rs1_reg  input  N  dividend.
REQ-008 rs2_reg  input  N  divisor.
REQ-009 req_rd  input  5  destination register tag.
REQ-010 wb_valid  output  1  result is available for writeback.
REQ-011 wb_ready  input  1  writeback port accepts the result.
REQ-012 wb_data  output  N  quotient or remainder.
REQ-013 wb_rd  output  5  tag returned with the result.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 A request SHALL be accepted on the rising edge where req_valid and req_ready are both high; op, operands and tag are latched on that edge.
REQ-016 The FSM SHALL have states IDLE, PREP, RUN, FIX and WB.
REQ-017 IDLE -> PREP on acceptance.
REQ-018 PREP -> WB for special cases; otherwise PREP -> RUN.
REQ-019 RUN -> FIX on core done; FIX -> WB.
REQ-020 WB -> IDLE on wb_valid && wb_ready.
REQ-021 In PREP, for signed ops (DIV, REM), the block SHALL form the magnitudes of both operands and record the quotient sign (rs1 sign XOR rs2 sign) and the remainder sign (rs1 sign).
REQ-022 Divide-by-zero (rs2==0) is a special case: quotient = all ones, remainder = rs1, and the core is not started.
REQ-023 Signed overflow (DIV/REM with rs1=100..0 and rs2=all ones) is a special case: quotient = rs1, remainder = 0.
REQ-024 In the first RUN cycle, the block SHALL drive a one-cycle start pulse to the core with the magnitudes.
REQ-025 The core SHALL return a quotient and remainder with done asserted exactly N cycles after start.
REQ-026 In FIX, a negative result sign SHALL be applied as two's-complement negation, modulo 2^N.
REQ-027 FIX SHALL select the quotient for DIV/DIVU and the remainder for REM/REMU.
REQ-028 Latency (normal): wb_valid SHALL rise N+3 cycles after the accepting edge.
REQ-029 Latency (special case): wb_valid SHALL rise 2 cycles after the accepting edge.
REQ-030 wb_valid, wb_data and wb_rd SHALL hold stable until wb_ready is sampled high, with no limit on backpressure.
REQ-031 The next request SHALL NOT be accepted until the cycle after the writeback handshake; there is no same-cycle accept on WB exit.
REQ-032 req_valid while busy SHALL be ignored and SHALL NOT alter the latched operands.
REQ-033 Operand changes after acceptance SHALL have no effect on the result.

Reset
REQ-034 While reset is low at a clock edge, the state SHALL become IDLE, and the following outputs SHALL be forced: wb_valid=0, wb_data=0, wb_rd=0, busy=0, req_ready=1.
REQ-035 Reset SHALL abort any in-flight operation, including in RUN or WB.
REQ-036 Reset SHALL also clear the core, so that no done pulse from an aborted operation is seen after reset.
REQ-037 The first request SHALL be accepted on the first edge after reset is released.

Structure
REQ-038 The op encoding and the FSM state enum SHALL live in the shared package div_pkg; N is passed as a parameter and is not a package constant.
REQ-039 The iterative divider SHALL be a sub-module named udiv_core (ports: clk, reset, start, dividend, divisor, quotient, remainder, done).
REQ-040 udiv_core SHALL be a restoring shift-subtract unit that produces one quotient bit per cycle.
REQ-041 div_ctrl SHALL contain no # delays and no simulation-only constructs in synthesizable paths.

Verification (N=16)
REQ-042 DIVU 100/7 -> wb_data=14 at 19 cycles after accept; REMU 100/7 -> 2.
REQ-043 DIV 0xFF9C(-100)/7 -> 0xFFF2(-14); REM same operands -> 0xFFFE(-2); DIV 100/0xFFF9(-7) -> 0xFFF2.
REQ-044 DIVU 5/0 -> 0xFFFF and REM 5/0 -> 5, each with wb_valid 2 cycles after accept.
REQ-045 DIV 0x8000/0xFFFF -> 0x8000 and REM 0x8000/0xFFFF -> 0.
REQ-046 Hold wb_ready low 3 cycles with req_valid high -> wb_data/wb_rd stable, req_ready low, second request accepted only the cycle after the handshake.
REQ-047 Assert reset during RUN -> next cycle req_ready=1, wb_valid=0, busy=0; a following DIVU 9/3 returns 3.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types for the divide controller: op encoding and FSM states.
// Small helpers classify an op as signed and/or remainder-producing.
package div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_WB
  } state_e;

  function automatic logic op_signed(op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_rem(op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/udiv_core.sv
// Restoring shift-subtract unsigned divider, one quotient bit per cycle.
// done pulses N cycles after the start cycle; start performs the first step.
module udiv_core #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         done
);

  localparam int CW = $clog2(N + 1);

  logic [N-1:0]  r_rem;
  logic [N-1:0]  r_quo;
  logic [N-1:0]  r_div;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;

  logic [N-1:0]  w_rem_in;
  logic [N-1:0]  w_quo_in;
  logic [N-1:0]  w_div_in;
  logic [N:0]    w_sh;
  logic [N:0]    w_diff;
  logic [CW-1:0] w_cnt_nx;

  assign w_rem_in = start ? '0 : r_rem;
  assign w_quo_in = start ? dividend : r_quo;
  assign w_div_in = start ? divisor : r_div;
  assign w_sh     = {w_rem_in, w_quo_in[N-1]};
  // MSB of the difference is the borrow: set means "do not subtract"
  assign w_diff   = w_sh - {1'b0, w_div_in};
  assign w_cnt_nx = start ? CW'(1) : r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start || r_busy) begin
        r_rem <= w_diff[N] ? w_sh[N-1:0] : w_diff[N-1:0];
        r_quo <= {w_quo_in[N-2:0], ~w_diff[N]};
        r_div <= w_div_in;
        r_cnt <= w_cnt_nx;
        if (w_cnt_nx == CW'(N)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_busy <= 1'b1;
        end
      end
    end
  end

  assign quotient  = r_quo;
  assign remainder = r_rem;
  assign done      = r_done;

endmodule

// File: rtl/div_ctrl.sv
// RV32M-style divide controller: sign prep, iterative core, sign fix.
// Special cases (div by zero, signed overflow) bypass the core.
module div_ctrl
  import div_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_op,
  input  logic [N-1:0] rs1_reg,
  input  logic [N-1:0] rs2_reg,
  input  logic [4:0]   req_rd,
  output logic         wb_valid,
  input  logic         wb_ready,
  output logic [N-1:0] wb_data,
  output logic [4:0]   wb_rd,
  output logic         busy
);

  localparam logic [N-1:0] MIN = {1'b1, {(N-1){1'b0}}};

  state_e       r_state;
  state_e       w_next;
  op_e          r_op;
  logic [N-1:0] r_a;
  logic [N-1:0] r_b;
  logic [N-1:0] r_amag;
  logic [N-1:0] r_bmag;
  logic [4:0]   r_rd;
  logic [N-1:0] r_wb_data;
  logic [4:0]   r_wb_rd;
  logic         r_qneg;
  logic         r_rneg;
  logic         r_hold;
  logic         r_started;

  logic         w_sgn;
  logic         w_rem;
  logic         w_aneg;
  logic         w_bneg;
  logic         w_zero;
  logic         w_ovf;
  logic         w_special;
  logic [N-1:0] w_spec_res;
  logic         w_start;
  logic         w_done;
  logic [N-1:0] w_quo;
  logic [N-1:0] w_remd;
  logic [N-1:0] w_res;
  logic         w_neg;
  logic [N-1:0] w_fixed;

  assign w_sgn      = op_signed(r_op);
  assign w_rem      = op_rem(r_op);
  assign w_aneg     = w_sgn & r_a[N-1];
  assign w_bneg     = w_sgn & r_b[N-1];
  assign w_zero     = (r_b == '0);
  assign w_ovf      = w_sgn && (r_a == MIN) && (r_b == '1);
  assign w_special  = w_zero | w_ovf;
  assign w_spec_res = w_zero ? (w_rem ? r_a : '1)
                             : (w_rem ? '0 : r_a);

  assign w_start = (r_state == S_RUN) && !r_started;
  assign w_res   = w_rem ? w_remd : w_quo;
  assign w_neg   = w_rem ? r_rneg : r_qneg;
  assign w_fixed = w_neg ? (~w_res + 1'b1) : w_res;

  udiv_core #(.N(N)) u_core (
    .clk       (clk),
    .reset     (reset),
    .start     (w_start),
    .dividend  (r_amag),
    .divisor   (r_bmag),
    .quotient  (w_quo),
    .remainder (w_remd),
    .done      (w_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    busy      = 1'b1;
    wb_valid  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) w_next = S_PREP;
      end
      S_PREP: begin
        if (!w_special)  w_next = S_RUN;
        else if (r_hold) w_next = S_WB;
      end
      S_RUN:  if (w_done) w_next = S_FIX;
      S_FIX:  w_next = S_WB;
      S_WB: begin
        wb_valid = 1'b1;
        if (wb_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_op      <= OP_DIV;
      r_a       <= '0;
      r_b       <= '0;
      r_rd      <= '0;
      r_amag    <= '0;
      r_bmag    <= '0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_hold    <= 1'b0;
      r_started <= 1'b0;
      r_wb_data <= '0;
      r_wb_rd   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (req_valid) begin
          r_op   <= op_e'(req_op);
          r_a    <= rs1_reg;
          r_b    <= rs2_reg;
          r_rd   <= req_rd;
          r_hold <= 1'b0;
        end
        S_PREP: begin
          r_amag    <= w_aneg ? (~r_a + 1'b1) : r_a;
          r_bmag    <= w_bneg ? (~r_b + 1'b1) : r_b;
          r_qneg    <= w_aneg ^ w_bneg;
          r_rneg    <= w_aneg;
          r_started <= 1'b0;
          // special results sit one cycle in a flop before WB
          if (w_special) begin
            r_hold    <= 1'b1;
            r_wb_data <= w_spec_res;
            r_wb_rd   <= r_rd;
          end
        end
        S_RUN: r_started <= 1'b1;
        S_FIX: begin
          r_wb_data <= w_fixed;
          r_wb_rd   <= r_rd;
        end
        default: ;
      endcase
    end
  end

  assign wb_data = r_wb_data;
  assign wb_rd   = r_wb_rd;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed-vector bench for div_ctrl at N=16.
// Inputs change #1 after posedge; outputs are sampled at the same point.
module tb_div_ctrl;

  localparam int N = 16;
  localparam logic [1:0] DIV  = 2'd0;
  localparam logic [1:0] DIVU = 2'd1;
  localparam logic [1:0] REM  = 2'd2;
  localparam logic [1:0] REMU = 2'd3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [1:0]   req_op = 2'd0;
  logic [N-1:0] rs1_reg = '0;
  logic [N-1:0] rs2_reg = '0;
  logic [4:0]   req_rd = '0;
  logic         wb_valid;
  logic         wb_ready = 1'b0;
  logic [N-1:0] wb_data;
  logic [4:0]   wb_rd;
  logic         busy;

  int n_chk = 0;
  int n_pass = 0;

  div_ctrl #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .rs1_reg   (rs1_reg),
    .rs2_reg   (rs2_reg),
    .req_rd    (req_rd),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_data   (wb_data),
    .wb_rd     (wb_rd),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, accept it, then keep req_valid high with
  // scrambled operands while waiting for wb_valid.
  task automatic issue_wait(input logic [1:0]   op,
                            input logic [N-1:0] a,
                            input logic [N-1:0] b,
                            input logic [4:0]   rd,
                            input int           lat,
                            input string        tag);
    int n;
    req_op    = op;
    rs1_reg   = a;
    rs2_reg   = b;
    req_rd    = rd;
    req_valid = 1'b1;
    tick();
    req_op  = ~op;
    rs1_reg = ~a;
    rs2_reg = b ^ 16'h5a5a;
    req_rd  = ~rd;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!wb_valid && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat));
  endtask

  task automatic finish_op(input logic [N-1:0] exp,
                           input logic [4:0]   rd,
                           input string        tag);
    req_valid = 1'b0;
    chk({tag, "_data"}, 32'(wb_data), 32'(exp));
    chk({tag, "_rd"}, 32'(wb_rd), 32'(rd));
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk({tag, "_idle"}, 32'(req_ready), 32'd1);
  endtask

  task automatic run_op(input logic [1:0]   op,
                        input logic [N-1:0] a,
                        input logic [N-1:0] b,
                        input logic [4:0]   rd,
                        input logic [N-1:0] exp,
                        input int           lat,
                        input string        tag);
    issue_wait(op, a, b, rd, lat, tag);
    finish_op(exp, rd, tag);
  endtask

  initial begin
    reset = 1'b0;
    tick();
    tick();
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wbv", 32'(wb_valid), 32'd0);
    chk("rst_data", 32'(wb_data), 32'd0);
    chk("rst_rd", 32'(wb_rd), 32'd0);
    reset = 1'b1;

    run_op(DIVU, 16'd100, 16'd7, 5'd1, 16'd14, 19, "divu");
    run_op(REMU, 16'd100, 16'd7, 5'd2, 16'd2, 19, "remu");
    run_op(DIV, 16'hFF9C, 16'd7, 5'd3, 16'hFFF2, 19, "div_nn");
    run_op(REM, 16'hFF9C, 16'd7, 5'd4, 16'hFFFE, 19, "rem_nn");
    run_op(DIV, 16'd100, 16'hFFF9, 5'd5, 16'hFFF2, 19, "div_pn");
    run_op(REM, 16'd100, 16'hFFF9, 5'd6, 16'd2, 19, "rem_pn");
    run_op(DIV, 16'hFF9C, 16'hFFF9, 5'd7, 16'd14, 19, "div_mm");
    run_op(DIVU, 16'hFFFF, 16'd1, 5'd8, 16'hFFFF, 19, "divu_max");
    run_op(REMU, 16'hFFFF, 16'h0010, 5'd9, 16'h000F, 19, "remu_max");
    run_op(DIVU, 16'd5, 16'd0, 5'd10, 16'hFFFF, 2, "divu_z");
    run_op(REM, 16'd5, 16'd0, 5'd11, 16'd5, 2, "rem_z");
    run_op(DIV, 16'd5, 16'd0, 5'd12, 16'hFFFF, 2, "div_z");
    run_op(DIV, 16'h8000, 16'hFFFF, 5'd13, 16'h8000, 2, "div_ovf");
    run_op(REM, 16'h8000, 16'hFFFF, 5'd14, 16'd0, 2, "rem_ovf");
    run_op(DIVU, 16'h8000, 16'hFFFF, 5'd15, 16'd0, 19, "divu_noovf");

    // backpressure with a competing request held high
    issue_wait(DIVU, 16'd100, 16'd7, 5'd3, 19, "bp");
    req_op    = DIVU;
    rs1_reg   = 16'd9;
    rs2_reg   = 16'd3;
    req_rd    = 5'd7;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_data", 32'(wb_data), 32'd14);
      chk("bp_rd", 32'(wb_rd), 32'd3);
      chk("bp_wbv", 32'(wb_valid), 32'd1);
      chk("bp_ready", 32'(req_ready), 32'd0);
      tick();
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk("bp_noacc", 32'(busy), 32'd0);
    chk("bp_rdy", 32'(req_ready), 32'd1);
    run_op(DIVU, 16'd9, 16'd3, 5'd7, 16'd3, 19, "bp_next");

    // reset in the middle of RUN
    req_op    = DIVU;
    rs1_reg   = 16'd100;
    rs2_reg   = 16'd7;
    req_rd    = 5'd9;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b0;
    tick();
    chk("mr_ready", 32'(req_ready), 32'd1);
    chk("mr_wbv", 32'(wb_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_data", 32'(wb_data), 32'd0);
    chk("mr_rd", 32'(wb_rd), 32'd0);
    reset = 1'b1;
    run_op(DIVU, 16'd9, 16'd3, 5'd2, 16'd3, 19, "mr_next");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
